branch_hazard_ctrl: RTL and testbench
=====================================

Name: branch_hazard_ctrl

Overview:
- ID-stage hazard controller paired with the branch forwarding unit; sits alongside the IF/ID and ID/EX pipeline registers.
- Decides when the ID instruction must wait until its operands are reachable through the MEM/WB forwarding paths.
- Drives PC/IF-ID hold, ID/EX bubble insertion and IF/ID flush on redirects.
- Keeps saturating stall and flush performance counters.

Parameters:
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- rs_ID  in  5  rs field of the instruction in ID
- rt_ID  in  5  rt field of the instruction in ID
- UseRt_ID  in  1  ID instruction reads rt
- Branch_ID  in  1  ID instruction is beq/bne
- Jr_ID  in  1  ID instruction is jr/jalr
- Jump_ID  in  1  ID instruction is j/jal
- BranchTaken_ID  in  1  branch comparator result, post-forwarding
- RegWrite_EX  in  1  EX instruction writes a register
- MemRead_EX  in  1  EX instruction is a load
- Rw_EX  in  5  EX destination register
- MemRead_MEM  in  1  MEM instruction is a load
- Rw_MEM  in  5  MEM destination register
- perf_clr  in  1  synchronous clear of both counters
- Stall  out  1  hold PC and IF/ID this cycle
- Bubble_IDEX  out  1  load a NOP into ID/EX this cycle
- Flush_IFID  out  1  squash the instruction in IF/ID
- stall_cycles  out  CNT_W  cycles with Stall=1, saturating
- flush_count  out  CNT_W  cycles with Flush_IFID=1, saturating

Behaviour:
- Definitions:
  - matchX(Rw) = Rw!=0 && (Rw==rs_ID || (UseRt_ID && Rw==rt_ID)).
  - For Jr_ID, only rs is compared.
  - Jr_ID=1 means rt is ignored regardless of UseRt_ID.
- Stall requirement N, evaluated combinationally:
  - BrUse = Branch_ID | Jr_ID.
  - BrUse && MemRead_EX && matchX(Rw_EX) -> N=2: the load result is taken from the WB path.
  - Else BrUse && RegWrite_EX && matchX(Rw_EX) -> N=1: the ALU result is taken from the MEM path.
  - Else BrUse && MemRead_MEM && matchX(Rw_MEM) -> N=1.
  - Else !BrUse && MemRead_EX && matchX(Rw_EX) -> N=1: ordinary load-use.
  - Else N=0.
- FSM states: IDLE, HOLD. Registered 1-bit remaining count `rem`.
- IDLE:
  - Stall = Bubble_IDEX = (N!=0).
  - N==2 -> go to HOLD with rem=1.
  - N==1 -> stay in IDLE; N is re-evaluated next cycle.
- HOLD:
  - Stall = Bubble_IDEX = 1, regardless of inputs.
  - Decrement rem; when rem==1, return to IDLE.
  - Net effect: a load feeding a branch costs exactly 2 stall cycles.
- Flush_IFID:
  - Asserted only in IDLE with N==0, when Jump_ID | Jr_ID | (Branch_ID & BranchTaken_ID).
  - Never asserted while Stall=1, because BranchTaken_ID is not trusted until operands are forwardable.
- Outputs are combinational from state and inputs; the only registered elements are state, rem and the counters.
- Counters:
  - Increment on the rising edge when the corresponding output is 1.
  - Saturate at all-ones, with no wrap.
  - perf_clr has priority over increment.
- Reset (reset=0, asynchronous):
  - state=IDLE, rem=0, stall_cycles=0, flush_count=0.
  - Consequently Stall and Flush_IFID follow the combinational inputs immediately after release.
- Reset asserted mid-HOLD aborts the hold; no residual stall after release.
- Register 0 never causes a hazard.
- Simultaneous EX load and MEM load both matching: EX takes priority (N=2).

Test Plan:
- lw $8 in EX (MemRead_EX=1, Rw_EX=8), beq rs=8 in ID -> Stall=Bubble=1 for exactly 2 cycles, then Stall=0; stall_cycles=2.
- add $9 in EX (RegWrite_EX=1, Rw_EX=9), bne rt=9 UseRt=1 -> Stall=1 for 1 cycle; with EX cleared, next cycle Stall=0. Then BranchTaken_ID=1 -> Flush_IFID=1 that cycle, flush_count=1.
- lw $5 in EX, add rs=5 in ID (non-branch) -> 1-cycle Stall; Rw_EX=0 with rs=0 -> no stall.
- Jr_ID=1 rs=3 while MemRead_MEM=1 Rw_MEM=3 -> Stall 1 cycle, Flush_IFID=0; next cycle with MEM clear -> Flush_IFID=1.
- Enter HOLD, assert reset=0 for 1 cycle -> Stall drops with no clock edge needed once inputs clear; counters read 0.
- Preload stall_cycles to all-ones by forcing Stall for 2^CNT_W cycles (CNT_W=4 override) -> holds 15; perf_clr with Stall=1 -> 0.

Source files
------------

// File: rtl/branch_hazard_ctrl.sv
// ID-stage hazard controller for a branch-forwarding pipeline: decides stalls,
// ID/EX bubbles and IF/ID flushes, and keeps saturating stall/flush counters.
module branch_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs_ID,
  input  logic [4:0]       rt_ID,
  input  logic             UseRt_ID,
  input  logic             Branch_ID,
  input  logic             Jr_ID,
  input  logic             Jump_ID,
  input  logic             BranchTaken_ID,
  input  logic             RegWrite_EX,
  input  logic             MemRead_EX,
  input  logic [4:0]       Rw_EX,
  input  logic             MemRead_MEM,
  input  logic [4:0]       Rw_MEM,
  input  logic             perf_clr,
  output logic             Stall,
  output logic             Bubble_IDEX,
  output logic             Flush_IFID,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_rem;
  logic             w_rem_nxt;
  logic             w_br_use;
  logic             w_match_ex;
  logic             w_match_mem;
  logic [1:0]       w_need;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // jr reads only rs, so its rt field never participates in the compare
  function automatic logic reg_match(input logic [4:0] rw, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic use_rt,
                                     input logic jr);
    reg_match = (rw != 5'd0) && ((rw == rs) || (use_rt && !jr && (rw == rt)));
  endfunction

  // Stall requirement: how many cycles until the ID operands become forwardable
  always_comb begin
    w_br_use    = Branch_ID | Jr_ID;
    w_match_ex  = reg_match(Rw_EX, rs_ID, rt_ID, UseRt_ID, Jr_ID);
    w_match_mem = reg_match(Rw_MEM, rs_ID, rt_ID, UseRt_ID, Jr_ID);
    w_need      = 2'd0;
    if (w_br_use && MemRead_EX && w_match_ex) begin
      w_need = 2'd2;
    end else if (w_br_use && RegWrite_EX && w_match_ex) begin
      w_need = 2'd1;
    end else if (w_br_use && MemRead_MEM && w_match_mem) begin
      w_need = 2'd1;
    end else if (!w_br_use && MemRead_EX && w_match_ex) begin
      w_need = 2'd1;
    end else begin
      w_need = 2'd0;
    end
  end

  // FSM next state and hazard outputs
  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    Stall       = 1'b0;
    Bubble_IDEX = 1'b0;
    Flush_IFID  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_need != 2'd0) begin
          Stall       = 1'b1;
          Bubble_IDEX = 1'b1;
          if (w_need == 2'd2) begin
            w_state_nxt = HOLD;
            w_rem_nxt   = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          // Redirect only once the comparator sees forwardable operands
          Flush_IFID = Jump_ID | Jr_ID | (Branch_ID & BranchTaken_ID);
        end
      end
      HOLD: begin
        Stall       = 1'b1;
        Bubble_IDEX = 1'b1;
        w_rem_nxt   = 1'b0;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_rem_nxt   = 1'b0;
      end
    endcase
  end

  // State and remaining-hold registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_rem   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
    end
  end

  // Saturating performance counters; clear wins over increment
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= {CNT_W{1'b0}};
      r_flush_cnt <= {CNT_W{1'b0}};
    end else if (perf_clr) begin
      r_stall_cnt <= {CNT_W{1'b0}};
      r_flush_cnt <= {CNT_W{1'b0}};
    end else begin
      if (Stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (Flush_IFID && (r_flush_cnt != {CNT_W{1'b1}})) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign stall_cycles = r_stall_cnt;
  assign flush_count  = r_flush_cnt;

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Directed bench for branch_hazard_ctrl with hand-computed expectations,
// using a 4-bit counter width so saturation is reachable quickly.
module tb_branch_hazard_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    rs_ID, rt_ID, Rw_EX, Rw_MEM;
  logic          UseRt_ID, Branch_ID, Jr_ID, Jump_ID, BranchTaken_ID;
  logic          RegWrite_EX, MemRead_EX, MemRead_MEM, perf_clr;
  logic          Stall, Bubble_IDEX, Flush_IFID;
  logic [CW-1:0] stall_cycles, flush_count;

  int n_total = 0;
  int n_bad   = 0;

  branch_hazard_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .rs_ID(rs_ID), .rt_ID(rt_ID), .UseRt_ID(UseRt_ID),
    .Branch_ID(Branch_ID), .Jr_ID(Jr_ID), .Jump_ID(Jump_ID),
    .BranchTaken_ID(BranchTaken_ID),
    .RegWrite_EX(RegWrite_EX), .MemRead_EX(MemRead_EX), .Rw_EX(Rw_EX),
    .MemRead_MEM(MemRead_MEM), .Rw_MEM(Rw_MEM), .perf_clr(perf_clr),
    .Stall(Stall), .Bubble_IDEX(Bubble_IDEX), .Flush_IFID(Flush_IFID),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr_in();
    rs_ID = 5'd0; rt_ID = 5'd0; UseRt_ID = 1'b0; Branch_ID = 1'b0; Jr_ID = 1'b0;
    Jump_ID = 1'b0; BranchTaken_ID = 1'b0; RegWrite_EX = 1'b0; MemRead_EX = 1'b0;
    Rw_EX = 5'd0; MemRead_MEM = 1'b0; Rw_MEM = 5'd0; perf_clr = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic s, input logic f);
    #1;
    check_val({tag, "_stall"}, 32'(Stall), 32'(s));
    check_val({tag, "_bubble"}, 32'(Bubble_IDEX), 32'(s));
    check_val({tag, "_flush"}, 32'(Flush_IFID), 32'(f));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    @(negedge clk);
  endtask

  initial begin
    clr_in();
    reset = 1'b0;
    #2;
    check_val("rst_stall", 32'(Stall), 32'd0);
    check_val("rst_scnt", 32'(stall_cycles), 32'd0);
    check_val("rst_fcnt", 32'(flush_count), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // lw $8 in EX feeding beq rs=8: two stall cycles
    MemRead_EX = 1'b1; RegWrite_EX = 1'b1; Rw_EX = 5'd8; Branch_ID = 1'b1; rs_ID = 5'd8;
    chk_out("lwbr_c1", 1'b1, 1'b0);
    tick();
    MemRead_EX = 1'b0; RegWrite_EX = 1'b0; Rw_EX = 5'd0;
    chk_out("lwbr_c2", 1'b1, 1'b0);
    tick();
    chk_out("lwbr_c3", 1'b0, 1'b0);
    tick();
    check_val("lwbr_scnt", 32'(stall_cycles), 32'd2);

    // rt compared only when UseRt_ID is set
    clr_in();
    RegWrite_EX = 1'b1; Rw_EX = 5'd9; Branch_ID = 1'b1; rs_ID = 5'd1; rt_ID = 5'd9;
    BranchTaken_ID = 1'b1;
    chk_out("nort", 1'b0, 1'b1);
    UseRt_ID = 1'b1;
    chk_out("alubr_c1", 1'b1, 1'b0);
    tick();
    RegWrite_EX = 1'b0; Rw_EX = 5'd0;
    chk_out("alubr_c2", 1'b0, 1'b1);
    tick();
    check_val("alubr_scnt", 32'(stall_cycles), 32'd3);
    check_val("alubr_fcnt", 32'(flush_count), 32'd1);

    // ordinary load-use, then $0 never hazards
    clr_in();
    MemRead_EX = 1'b1; RegWrite_EX = 1'b1; Rw_EX = 5'd5; rs_ID = 5'd5;
    chk_out("ldu", 1'b1, 1'b0);
    tick();
    Rw_EX = 5'd0; rs_ID = 5'd0;
    chk_out("r0", 1'b0, 1'b0);
    tick();
    check_val("ldu_scnt", 32'(stall_cycles), 32'd4);

    // jr ignores rt even with UseRt_ID set, then MEM load on rs stalls
    clr_in();
    Jr_ID = 1'b1; rs_ID = 5'd4; rt_ID = 5'd3; UseRt_ID = 1'b1; MemRead_MEM = 1'b1; Rw_MEM = 5'd3;
    chk_out("jr_rt", 1'b0, 1'b1);
    rs_ID = 5'd3;
    chk_out("jr_c1", 1'b1, 1'b0);
    tick();
    MemRead_MEM = 1'b0; Rw_MEM = 5'd0;
    chk_out("jr_c2", 1'b0, 1'b1);
    tick();
    check_val("jr_scnt", 32'(stall_cycles), 32'd5);
    check_val("jr_fcnt", 32'(flush_count), 32'd2);

    // EX load and MEM load both matching: EX wins, hold lasts 2 cycles
    clr_in();
    MemRead_EX = 1'b1; Rw_EX = 5'd7; MemRead_MEM = 1'b1; Rw_MEM = 5'd7;
    Branch_ID = 1'b1; rs_ID = 5'd7;
    chk_out("prio_c1", 1'b1, 1'b0);
    tick();
    MemRead_EX = 1'b0; Rw_EX = 5'd0; MemRead_MEM = 1'b0; Rw_MEM = 5'd0; BranchTaken_ID = 1'b1;
    chk_out("prio_c2", 1'b1, 1'b0);
    BranchTaken_ID = 1'b0;
    tick();
    chk_out("prio_c3", 1'b0, 1'b0);
    check_val("prio_scnt", 32'(stall_cycles), 32'd7);

    // reset during HOLD aborts the hold immediately
    clr_in();
    MemRead_EX = 1'b1; Rw_EX = 5'd8; Branch_ID = 1'b1; rs_ID = 5'd8;
    tick();
    clr_in();
    chk_out("hold_pre", 1'b1, 1'b0);
    reset = 1'b0;
    chk_out("hold_rst", 1'b0, 1'b0);
    check_val("hold_rst_scnt", 32'(stall_cycles), 32'd0);
    check_val("hold_rst_fcnt", 32'(flush_count), 32'd0);
    tick();
    reset = 1'b1;
    chk_out("hold_rel", 1'b0, 1'b0);

    // saturation at 15 with 4-bit counters, then clear beats increment
    MemRead_EX = 1'b1; Rw_EX = 5'd5; rs_ID = 5'd5;
    for (int i = 0; i < 15; i++) tick();
    check_val("sat_15", 32'(stall_cycles), 32'd15);
    for (int i = 0; i < 5; i++) tick();
    check_val("sat_hold", 32'(stall_cycles), 32'd15);
    perf_clr = 1'b1;
    chk_out("clr_stall", 1'b1, 1'b0);
    tick();
    check_val("clr_scnt", 32'(stall_cycles), 32'd0);
    perf_clr = 1'b0;
    tick();
    check_val("after_clr_scnt", 32'(stall_cycles), 32'd1);

    // jump always flushes when no stall
    clr_in();
    Jump_ID = 1'b1;
    chk_out("jump", 1'b0, 1'b1);
    tick();
    check_val("jump_fcnt", 32'(flush_count), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
